uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_CLK_BIT = 625;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Presets to 1 so the line looks idle during and right after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Double-register the async input; preset both stages to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Break conditions report one framing error, then wait for idle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_BIT = UART_CLK_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLK_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLK_BIT - 1);

    uart_state_t state;
    uart_state_t nstate;

    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sreg;
    logic        brk;

    logic        bit_end;
    logic        data_samp;
    logic        stop_samp;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    // Next-state logic and sample strobes.
    always_comb begin
        nstate    = state;
        bit_end   = 1'b0;
        data_samp = 1'b0;
        stop_samp = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s && !brk) nstate = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    bit_end = 1'b1;
                    nstate  = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    bit_end   = 1'b1;
                    data_samp = 1'b1;
                    if (idx == 3'd7) nstate = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    bit_end   = 1'b1;
                    stop_samp = 1'b1;
                    nstate    = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // Bit-period counter: clears on state change or at each sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             cnt <= '0;
        else if (nstate != state || bit_end)  cnt <= '0;
        else if (state != IDLE)               cnt <= cnt + 16'd1;
    end

    // Bit index and shift register for the data bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            sreg <= '0;
        end else if (state == START) begin
            idx <= '0;
        end else if (data_samp) begin
            sreg[idx] <= rx_s;
            idx       <= idx + 3'd1;
        end
    end

    // Registered result pulses and the output data holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= stop_samp && rx_s;
            frame_err <= stop_samp && !rx_s;
            if (stop_samp && rx_s) data <= sreg;
        end
    end

    // After a framing error, hold off new starts until the line idles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     brk <= 1'b0;
        else if (stop_samp && !rx_s)  brk <= 1'b1;
        else if (rx_s)                brk <= 1'b0;
    end

    assign busy = (state != IDLE);

endmodule
